ex_mem_pipe_reg: RTL
====================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register for the OpenMIPS core. Adds stall/flush control,
//  a valid bit, load/store operand forwarding and HI/LO write fields.
//  Also holds multi-cycle EX state (MADD/MSUB temp HILO and cycle count) across EX stalls.
//  Sits between the ex and mem stages; ctrl drives stall/flush.
// PARAMETERS
//  DATA_W   32  datapath width (GPR, HI, LO, memory address)
//  ADDR_W    5  register-file address width
//  ALUOP_W   8  ALU opcode width forwarded to mem
//  CNT_W     2  width of the multi-cycle step counter
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          synchronous, active-high reset
//  flush        in   1          exception flush, kills the instruction entering MEM
//  stall_ex     in   1          ctrl stall bit for EX
//  stall_mem    in   1          ctrl stall bit for MEM
//  ex_valid     in   1          EX holds a real instruction
//  ex_wd        in   ADDR_W     destination GPR
//  ex_wreg      in   1          GPR write enable
//  ex_wdata     in   DATA_W     GPR write data
//  ex_whilo     in   1          HI/LO write enable
//  ex_hi/ex_lo  in   DATA_W     HI/LO write data
//  ex_aluop     in   ALUOP_W    opcode for load/store decode in mem
//  ex_mem_addr  in   DATA_W     effective address
//  ex_reg2      in   DATA_W     store data
//  hilo_tmp_i   in   2*DATA_W   partial MADD/MSUB product from EX
//  cnt_i        in   CNT_W      multi-cycle step from EX
//  mem_valid    out  1          MEM holds a real instruction
//  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
//  mem_aluop, mem_mem_addr, mem_reg2   out  (widths as inputs)   registered copies
//  hilo_tmp_o   out  2*DATA_W   held partial product, back to EX
//  cnt_o        out  CNT_W      held step count, back to EX
// BEHAVIOUR
//  - Reset: every output 0. mem_wreg/mem_whilo = WriteDisable. mem_wd = 0.
//  - Latency: 1 cycle EX->MEM. No combinational path from input to output.
//  - Per-edge priority, first match wins:
//    1 rst: all outputs to 0.
//    2 flush: MEM fields to 0 (bubble), mem_valid=0; hilo_tmp_o=0, cnt_o=0.
//    3 stall_ex & !stall_mem: MEM fields bubble (as flush).
//      Capture hilo_tmp_o<=hilo_tmp_i and cnt_o<=cnt_i.
//    4 stall_ex & stall_mem: hold all outputs unchanged.
//    5 !stall_ex: advance every MEM field from ex_*, mem_valid<=ex_valid.
//      Clear hilo_tmp_o=0, cnt_o=0.
//  - !stall_ex & stall_mem is illegal (ctrl never drives it). Treat it as case 4 (hold).
//  - Bubble: wreg=whilo=0, aluop=0 (NOP), data/addr fields 0, valid=0.
//  - A bubble must never write the GPR or HI/LO, regardless of ex_* contents.
//  - Multi-cycle MADD over two EX cycles:
//    cycle1 stall_ex=1 -> cnt_o=1, hilo_tmp_o=product.
//    cycle2 EX consumes hilo_tmp_o, stall_ex=0 -> result advances, temp cleared.
//  - flush during a multi-cycle op discards the held temp. Reset likewise.
//  - ex_valid=0 with !stall_ex still advances. mem_valid=0; other fields copied verbatim.
// CONFIGURATION
//  EX_MEM_HILO_EN defined:
//    whilo/hi/lo and hilo_tmp/cnt paths registered as above.
//  EX_MEM_HILO_EN undefined:
//    Ports remain. mem_whilo, mem_hi, mem_lo, hilo_tmp_o and cnt_o are tied to constant 0.
//    Their inputs are ignored, and no flops are inferred for them.
//    Stall/flush/valid behaviour is otherwise identical.
// TESTING
//  1 rst=1 for 2 cycles with random ex_* -> all outputs 0. Release: next edge copies ex_*.
//  2 ex_wd=5,ex_wreg=1,ex_wdata=32'hDEADBEEF,valid=1, no stall:
//    -> after 1 edge mem_wd=5, mem_wdata=DEADBEEF, mem_valid=1.
//  3 Hold: stall_ex=stall_mem=1 for 3 cycles while ex_* changes -> outputs frozen at prior value.
//  4 stall_ex=1,stall_mem=0 with ex_wreg=1 -> mem_wreg=0, mem_valid=0.
//    hilo_tmp_i=64'h1_0000_0002 and cnt_i=1 -> latched on hilo_tmp_o/cnt_o.
//  5 Same setup as 4, then flush=1 -> temp cleared. Flush+stall same edge -> flush wins (bubble, temp 0).
//  6 Macro off: ex_whilo=1, ex_hi=32'h1234 -> mem_whilo=0, mem_hi=0. Macro on -> mem_hi=32'h1234.

Source files
------------

// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM pipeline bus: EX-side result fields in, registered MEM-side fields out,
// plus the multi-cycle MADD/MSUB temp state looped back to EX.
interface ex_mem_pipe_reg_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ALUOP_W = 8,
  parameter int unsigned CNT_W   = 2
);
  logic                ex_valid;
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [DATA_W-1:0]   ex_mem_addr;
  logic [DATA_W-1:0]   ex_reg2;
  logic [2*DATA_W-1:0] hilo_tmp_i;
  logic [CNT_W-1:0]    cnt_i;

  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [ALUOP_W-1:0]  mem_aluop;
  logic [DATA_W-1:0]   mem_mem_addr;
  logic [DATA_W-1:0]   mem_reg2;
  logic [2*DATA_W-1:0] hilo_tmp_o;
  logic [CNT_W-1:0]    cnt_o;

  // EX stage side
  modport master (
    output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop,
           ex_mem_addr, ex_reg2, hilo_tmp_i, cnt_i,
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_tmp_o, cnt_o
  );

  // Pipeline register side
  modport slave (
    input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop,
           ex_mem_addr, ex_reg2, hilo_tmp_i, cnt_i,
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_tmp_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall/flush/valid and held MADD/MSUB temp state.
// Define EX_MEM_HILO_EN to register the HI/LO write fields and the hilo_tmp/cnt loop.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ALUOP_W = 8,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  ex_mem_pipe_reg_if.slave      bus
);

  typedef enum logic [1:0] {ActHold, ActAdvance, ActBubble, ActFlush} act_e;

  act_e act;

  // Flush beats stall; !stall_ex & stall_mem cannot occur and falls into hold.
  always_comb begin
    act = ActHold;
    if (flush) begin
      act = ActFlush;
    end else if (stall_ex && !stall_mem) begin
      act = ActBubble;
    end else if (!stall_ex && !stall_mem) begin
      act = ActAdvance;
    end
  end

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  wd_q, wd_d;
  logic               wreg_q, wreg_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  reg2_q, reg2_d;

  always_comb begin
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    aluop_d = aluop_q;
    addr_d  = addr_q;
    reg2_d  = reg2_q;
    unique case (act)
      ActAdvance: begin
        valid_d = bus.ex_valid;
        wd_d    = bus.ex_wd;
        wreg_d  = bus.ex_wreg;
        wdata_d = bus.ex_wdata;
        aluop_d = bus.ex_aluop;
        addr_d  = bus.ex_mem_addr;
        reg2_d  = bus.ex_reg2;
      end
      ActBubble, ActFlush: begin
        valid_d = 1'b0;
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = '0;
        aluop_d = '0;
        addr_d  = '0;
        reg2_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      aluop_q <= '0;
      addr_q  <= '0;
      reg2_q  <= '0;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      aluop_q <= aluop_d;
      addr_q  <= addr_d;
      reg2_q  <= reg2_d;
    end
  end

  assign bus.mem_valid    = valid_q;
  assign bus.mem_wd       = wd_q;
  assign bus.mem_wreg     = wreg_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_aluop    = aluop_q;
  assign bus.mem_mem_addr = addr_q;
  assign bus.mem_reg2     = reg2_q;

`ifdef EX_MEM_HILO_EN
  logic                whilo_q, whilo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [2*DATA_W-1:0] tmp_q, tmp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Temp state is only kept while EX stalls alone; any advance or flush retires it.
  always_comb begin
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    tmp_d   = tmp_q;
    cnt_d   = cnt_q;
    unique case (act)
      ActAdvance: begin
        whilo_d = bus.ex_whilo;
        hi_d    = bus.ex_hi;
        lo_d    = bus.ex_lo;
        tmp_d   = '0;
        cnt_d   = '0;
      end
      ActBubble: begin
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
        tmp_d   = bus.hilo_tmp_i;
        cnt_d   = bus.cnt_i;
      end
      ActFlush: begin
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
        tmp_d   = '0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tmp_q   <= tmp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_whilo  = whilo_q;
  assign bus.mem_hi     = hi_q;
  assign bus.mem_lo     = lo_q;
  assign bus.hilo_tmp_o = tmp_q;
  assign bus.cnt_o      = cnt_q;
`else
  logic unused_hilo;
  assign unused_hilo = ^{bus.ex_whilo, bus.ex_hi, bus.ex_lo, bus.hilo_tmp_i, bus.cnt_i};

  assign bus.mem_whilo  = 1'b0;
  assign bus.mem_hi     = DATA_W'(0);
  assign bus.mem_lo     = DATA_W'(0);
  assign bus.hilo_tmp_o = (2 * DATA_W)'(0);
  assign bus.cnt_o      = CNT_W'(0);
`endif

endmodule
